hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//  Player-input judge stage that sits directly downstream of the note shifter.
//  Synchronises and debounces the red/blue hit buttons, then compares each press with the note
//  at the judge position (note_R_judge / note_B_judge, phase offset).
//  Drives the shifter's delete pulse on a correct hit and keeps score, hit/miss counts and the
//  last judgement for display.
// PARAMETERS
//  DB_CYCLES    20'd499999  stable cycles before a button level is accepted (10 ms @ 50 MHz)
//  PERFECT_LO   3'd2        lowest offset graded PERFECT
//  PERFECT_HI   3'd4        highest offset graded PERFECT
//  PERFECT_PTS  16'd3       score added for PERFECT
//  GOOD_PTS     16'd1       score added for GOOD
//  HOLD_CYCLES  24'd9999999 cycles judge_result is held before returning to NONE
//  WAIT_MAX     17'd29999   watchdog on WAIT_CLR (one shifter note step)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  red_button    in   1   raw red hit button, asynchronous, active-high
//  blue_button   in   1   raw blue hit button, asynchronous, active-high
//  note_R_judge  in   1   red note present at judge position
//  note_B_judge  in   1   blue note present at judge position
//  offset        in   3   note phase 0..6 from shifter
//  finish        in   1   song-finished level from shifter
//  clear         in   1   1-cycle pulse: zero score/counters
//  delete        out  1   1-cycle pulse: remove judged note
//  score         out  16  accumulated score, saturating
//  hit_cnt       out  10  correct hits, saturating at 1023
//  miss_cnt      out  10  wrong-colour presses, saturating at 1023
//  judge_result  out  2   0 NONE, 1 PERFECT, 2 GOOD, 3 MISS
// BEHAVIOUR
//  Reset: all outputs 0, FSM in ARMED, debounced levels 0, debounce/hold/watchdog counters 0.
//  Input path, per button:
//   - 2-FF synchroniser, then debounce counter.
//   - Counter resets on any mismatch between synced and debounced level.
//   - Debounced level flips when the counter reaches DB_CYCLES.
//   - Rising edge of the debounced level gives press_r / press_b (1 cycle).
//   - Latency from a clean raw edge to the press pulse is 2+DB_CYCLES+1 cycles.
//  Grade: PERFECT if PERFECT_LO <= offset <= PERFECT_HI, else GOOD. Offset is sampled in the press cycle.
//  FSM states ARMED, DELETE, WAIT_CLR, LOCKED:
//   ARMED:
//    - finish=1 -> LOCKED.
//    - press_r & press_b in the same cycle -> MISS, no delete, stay.
//    - press_r with note_R_judge, or press_b with note_B_judge -> grade, add points, hit_cnt+1 -> DELETE.
//    - press of a colour not present while the other colour is present -> MISS, miss_cnt+1, stay.
//    - press with no note present (both judge=0) -> ignored, no counters change.
//   DELETE: delete=1 for exactly this cycle -> WAIT_CLR.
//   WAIT_CLR:
//    - Presses are ignored.
//    - Exit to ARMED when note_R_judge=0 and note_B_judge=0, or when the watchdog reaches WAIT_MAX.
//    - Guarantees one hit per note.
//   LOCKED:
//    - Presses are ignored; delete stays 0; score and counters are frozen.
//    - Return to ARMED when finish=0.
//  judge_result:
//   - Loads on every graded press or MISS.
//   - Hold counter restarts on each load; returns to NONE after HOLD_CYCLES.
//  Arithmetic: score += pts, clamped to 16'hFFFF. Counters clamp at 10'd1023.
//  Simultaneous events:
//   - clear in the same cycle as a hit: clear wins (counters 0); the delete pulse is still issued.
//   - finish rising while in DELETE: the pulse completes, then the FSM goes to LOCKED at the WAIT_CLR exit.
//  Reset mid-operation: returns to reset values immediately. A button held through reset produces no press until it is released and pressed again.
// STRUCTURE
//  Shared package/header: judge_result codes (NONE/PERFECT/GOOD/MISS), FSM state encodings, colour codes 2'd1 red / 2'd2 blue.
//  Sub-module: btn_debounce (synchroniser + debounce + edge detect), instantiated twice.
//  The FSM, score datapath and hold counter stay in the top module.
// TESTING  (bench overrides DB_CYCLES=4, HOLD_CYCLES=16, WAIT_MAX=8)
//  1. Red PERFECT:
//     - Stimulus: note_R_judge=1, offset=3, clean red press.
//     - Response: delete pulses 1 cycle, score=3, hit_cnt=1, judge_result=1.
//     - Then drop note_R_judge -> FSM back to ARMED.
//  2. Blue GOOD then re-press on the same note:
//     - Stimulus: note_B_judge=1, offset=6, press; press again while the note is held.
//     - Response: score=1, one delete only, hit_cnt=1.
//  3. Wrong colour:
//     - Stimulus: note_R_judge=1, blue press.
//     - Response: miss_cnt=1, judge_result=3, no delete, score unchanged.
//  4. Bounce:
//     - Stimulus: red toggles every 2 cycles for 20 cycles, then held high.
//     - Response: exactly one press_r, 7 cycles after the last toggle.
//  5. Finish lock:
//     - Stimulus: finish=1, red press with note_R_judge=1.
//     - Response: no delete, counters frozen; clear pulse -> score=0, hit_cnt=0, miss_cnt=0.
//  6. Saturation and watchdog:
//     - Stimulus: preload score=16'hFFFE, then a PERFECT hit.
//     - Response: score=16'hFFFF.
//     - Stimulus: hold note_R_judge=1 after a hit.
//     - Response: ARMED after 8 cycles in WAIT_CLR.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge stage: judgement codes, FSM state
// encoding, colour codes and saturating arithmetic helpers.
package hit_judge_pkg;

  // judge_result codes driven to the display
  typedef enum logic [1:0] {
    JR_NONE    = 2'd0,
    JR_PERFECT = 2'd1,
    JR_GOOD    = 2'd2,
    JR_MISS    = 2'd3
  } judge_t;

  // Judge FSM states
  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_DELETE   = 2'd1,
    ST_WAIT_CLR = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  // Colour codes, also used as bit positions in {blue, red} vectors
  localparam logic [1:0] COL_RED  = 2'd1;
  localparam logic [1:0] COL_BLUE = 2'd2;

  // 16-bit add clamped at all-ones
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // 10-bit increment clamped at 1023
  function automatic logic [9:0] sat_inc10(input logic [9:0] a);
    return (a == 10'd1023) ? a : a + 10'd1;
  endfunction

endpackage

// File: rtl/hit_judge_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and rising-edge detect
// for one raw push button.
//   clk_i    system clock
//   rst_i    asynchronous reset, active-high
//   btn_i    raw asynchronous button level, active-high
//   press_o  one-cycle pulse on each accepted press
// Latency from a clean raw edge to press_o is 2 + DB_CYCLES + 1 cycles.
module btn_debounce #(
  parameter logic [19:0] DB_CYCLES = 20'd499999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        prev_q;
  logic        primed_q, primed_d;
  logic [1:0]  fill_q;
  logic [19:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      fill_q   <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      fill_q   <= {fill_q[0], 1'b1};
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      prev_q   <= level_q;
      primed_q <= primed_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_CYCLES) level_d = sync2_q;
      else                    cnt_d   = cnt_q + 20'd1;
    end
  end

  // A button held through reset must be seen released once the synchroniser
  // holds real post-reset samples before any press is reported.
  always_comb primed_d = primed_q | (fill_q[1] & ~sync2_q);

  assign press_o = level_q & ~prev_q & primed_q;

endmodule

// File: rtl/hit_judge.sv
// hit_judge: player-input judge stage downstream of the note shifter.
// Debounces the red/blue buttons, compares each press with the note at the
// judge position, pulses delete on a correct hit and keeps score, hit/miss
// counts and the last judgement for display.
//   clk, rst                  clock, asynchronous active-high reset
//   red_button, blue_button   raw hit buttons
//   note_R_judge/note_B_judge note present at judge position
//   offset                    note phase 0..6
//   finish                    song-finished level (locks judging)
//   clear                     1-cycle pulse zeroing score and counters
//   delete                    1-cycle pulse removing the judged note
//   score, hit_cnt, miss_cnt  saturating counters
//   judge_result              0 NONE, 1 PERFECT, 2 GOOD, 3 MISS
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES   = 20'd499999,
  parameter logic [2:0]  PERFECT_LO  = 3'd2,
  parameter logic [2:0]  PERFECT_HI  = 3'd4,
  parameter logic [15:0] PERFECT_PTS = 16'd3,
  parameter logic [15:0] GOOD_PTS    = 16'd1,
  parameter logic [23:0] HOLD_CYCLES = 24'd9999999,
  parameter logic [16:0] WAIT_MAX    = 17'd29999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  input  logic        clear,
  output logic        delete,
  output logic [15:0] score,
  output logic [9:0]  hit_cnt,
  output logic [9:0]  miss_cnt,
  output logic [1:0]  judge_result
);

  logic        press_r, press_b;
  logic [1:0]  press_vec, note_vec;
  logic        perfect;

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  hit_q, hit_d;
  logic [9:0]  miss_q, miss_d;
  judge_t      res_q, res_d;
  logic [23:0] hold_q, hold_d;
  logic [16:0] wd_q, wd_d;
  logic        load;
  judge_t      load_val;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_red (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (red_button),
    .press_o (press_r)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_blue (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (blue_button),
    .press_o (press_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARMED;
      score_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      res_q   <= JR_NONE;
      hold_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    press_vec = {press_b, press_r};
    note_vec  = {note_B_judge, note_R_judge};
    perfect   = (offset >= PERFECT_LO) && (offset <= PERFECT_HI);

    state_d  = state_q;
    score_d  = score_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    wd_d     = '0;
    load     = 1'b0;
    load_val = JR_NONE;

    case (state_q)
      ST_ARMED: begin
        if (finish) begin
          state_d = ST_LOCKED;
        end else if (press_vec == (COL_RED | COL_BLUE)) begin
          load     = 1'b1;
          load_val = JR_MISS;
        end else if ((press_vec & note_vec) != 2'b00) begin
          load  = 1'b1;
          hit_d = sat_inc10(hit_q);
          if (perfect) begin
            load_val = JR_PERFECT;
            score_d  = sat_add16(score_q, PERFECT_PTS);
          end else begin
            load_val = JR_GOOD;
            score_d  = sat_add16(score_q, GOOD_PTS);
          end
          state_d = ST_DELETE;
        end else if ((press_vec != 2'b00) && (note_vec != 2'b00)) begin
          load     = 1'b1;
          load_val = JR_MISS;
          miss_d   = sat_inc10(miss_q);
        end
      end
      ST_DELETE: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        // Finish raised during DELETE/WAIT_CLR takes effect at this exit.
        if ((note_vec == 2'b00) || (wd_q == WAIT_MAX))
          state_d = finish ? ST_LOCKED : ST_ARMED;
        else
          wd_d = wd_q + 17'd1;
      end
      ST_LOCKED: if (!finish) state_d = ST_ARMED;
      default:   state_d = ST_ARMED;
    endcase

    // clear overrides any same-cycle counter update; the delete still issues
    if (clear) begin
      score_d = '0;
      hit_d   = '0;
      miss_d  = '0;
    end
  end

  always_comb begin
    res_d  = res_q;
    hold_d = hold_q;
    if (load) begin
      res_d  = load_val;
      hold_d = '0;
    end else if (res_q != JR_NONE) begin
      if (hold_q == HOLD_CYCLES) begin
        res_d  = JR_NONE;
        hold_d = '0;
      end else begin
        hold_d = hold_q + 24'd1;
      end
    end
  end

  assign delete       = (state_q == ST_DELETE);
  assign score        = score_q;
  assign hit_cnt      = hit_q;
  assign miss_cnt     = miss_q;
  assign judge_result = res_q;

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst, red_button, blue_button, note_R_judge, note_B_judge;
  logic        finish, clear, delete;
  logic [2:0]  offset;
  logic [15:0] score;
  logic [9:0]  hit_cnt, miss_cnt;
  logic [1:0]  judge_result;

  int n_tests = 0;
  int n_fail  = 0;
  int del_cnt = 0;

  // reference state, derived from the judging rules only
  int m_score, m_hit, m_miss, m_result, m_del;
  bit m_locked;

  hit_judge #(
    .DB_CYCLES  (20'd4),
    .HOLD_CYCLES(24'd16),
    .WAIT_MAX   (17'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red_button   (red_button),
    .blue_button  (blue_button),
    .note_R_judge (note_R_judge),
    .note_B_judge (note_B_judge),
    .offset       (offset),
    .finish       (finish),
    .clear        (clear),
    .delete       (delete),
    .score        (score),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .judge_result (judge_result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (delete === 1'b1) del_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/score"}, 32'(score), m_score);
    chk({tag, "/hit_cnt"}, 32'(hit_cnt), m_hit);
    chk({tag, "/miss_cnt"}, 32'(miss_cnt), m_miss);
    chk({tag, "/judge_result"}, 32'(judge_result), m_result);
  endtask

  task automatic model_reset();
    m_score = 0; m_hit = 0; m_miss = 0; m_result = 0; m_locked = 0;
  endtask

  // Outcome of one accepted press; previous judgement assumed expired.
  task automatic model_press(input bit nr, input bit nb, input int off,
                             input bit pr, input bit pb, input bit clr,
                             output bit exp_del);
    int pts;
    exp_del  = 0;
    m_result = 0;
    if (!m_locked) begin
      if (pr && pb) begin
        m_result = 3;
      end else if ((pr && nr) || (pb && nb)) begin
        pts      = (off >= 2 && off <= 4) ? 3 : 1;
        m_score  = (m_score + pts > 65535) ? 65535 : m_score + pts;
        m_hit    = (m_hit < 1023) ? m_hit + 1 : 1023;
        m_result = (pts == 3) ? 1 : 2;
        exp_del  = 1;
        m_del++;
      end else if ((pr || pb) && (nr || nb)) begin
        m_miss   = (m_miss < 1023) ? m_miss + 1 : 1023;
        m_result = 3;
      end
    end
    if (clr) begin
      m_score = 0; m_hit = 0; m_miss = 0;
    end
  endtask

  // Clean 5-cycle press; outputs checked right after the judging edge,
  // then the delete pulse width one cycle later.
  task automatic trial(input bit nr, input bit nb, input int off,
                       input bit pr, input bit pb, input bit clr);
    bit exp_del;
    note_R_judge = nr; note_B_judge = nb; offset = 3'(off);
    red_button = pr; blue_button = pb;
    tick(5);
    red_button = 0; blue_button = 0;
    tick(2);
    clear = clr;
    tick(1);
    clear = 0;
    model_press(nr, nb, off, pr, pb, clr, exp_del);
    chk("delete_pulse", 32'(delete), 32'(exp_del));
    check_outputs("trial");
    tick(1);
    chk("delete_width", 32'(delete), 0);
  endtask

  task automatic settle();
    note_R_judge = 0; note_B_judge = 0;
    tick(25);
  endtask

  initial begin
    int d0;
    bit exp_del;
    bit nr, nb, pr, pb, clr;
    int c, off;

    rst = 1; red_button = 0; blue_button = 0; note_R_judge = 0; note_B_judge = 0;
    finish = 0; clear = 0; offset = 0; m_del = 0;
    model_reset();
    tick(2);
    chk("reset/delete", 32'(delete), 0);
    check_outputs("reset");
    rst = 0;
    tick(5);

    // red PERFECT and judgement hold time
    trial(1, 0, 3, 1, 0, 0);
    tick(15);
    chk("hold_last_cycle", 32'(judge_result), 1);
    tick(1);
    chk("hold_expired", 32'(judge_result), 0);
    settle();

    // blue GOOD, then a second press while the note is still held
    #1 d0 = del_cnt;
    trial(0, 1, 6, 0, 1, 0);
    tick(1);
    blue_button = 1;
    tick(5);
    blue_button = 0;
    tick(20);
    #1 chk("repress_one_delete", 32'(del_cnt), 32'(d0 + 1));
    chk("repress_score", 32'(score), m_score);
    chk("repress_hit", 32'(hit_cnt), m_hit);
    settle();

    // wrong colour
    trial(1, 0, $urandom_range(0, 6), 0, 1, 0);
    settle();

    // bouncing red button, final level high
    note_R_judge = 1; offset = 3'd5;
    #1 d0 = del_cnt;
    for (int k = 0; k <= 10; k++) begin
      red_button = (k % 2 == 0);
      if (k != 10) tick(2);
    end
    tick(7);
    chk("bounce_early", 32'(delete), 0);
    tick(1);
    chk("bounce_delete", 32'(delete), 1);
    model_press(1, 0, 5, 1, 0, 0, exp_del);
    check_outputs("bounce");
    red_button = 0;
    tick(20);
    #1 chk("bounce_single", 32'(del_cnt), 32'(d0 + 1));
    settle();

    // finish lock, then clear
    finish = 1;
    tick(2);
    m_locked = 1;
    trial(1, 0, 3, 1, 0, 0);
    clear = 1;
    tick(1);
    clear = 0;
    m_score = 0; m_hit = 0; m_miss = 0;
    check_outputs("lock_clear");
    finish = 0;
    m_locked = 0;
    tick(2);
    settle();

    // clear coinciding with a hit: counters zero, delete still issued
    trial(1, 0, 4, 1, 0, 0);
    settle();
    trial(0, 1, 2, 0, 1, 1);
    settle();

    // score saturation and watchdog exit with the note held
    force dut.score_q = 16'hFFFE;
    tick(1);
    release dut.score_q;
    m_score = 65534;
    tick(1);
    chk("preload", 32'(score), m_score);
    trial(1, 0, 4, 1, 0, 0);
    tick(30);
    trial(1, 0, 2, 1, 0, 0);
    settle();

    // reset with button held: no press until released and pressed again
    note_R_judge = 1; offset = 3'd3; red_button = 1;
    tick(2);
    rst = 1;
    model_reset();
    #1 d0 = del_cnt;
    tick(2);
    check_outputs("reset_mid");
    rst = 0;
    tick(20);
    #1 chk("held_no_press", 32'(del_cnt), 32'(d0));
    chk("held_score", 32'(score), 0);
    red_button = 0;
    tick(15);
    trial(1, 0, 3, 1, 0, 0);
    settle();

    // randomized presses against the reference
    repeat (40) begin
      nr  = 1'($urandom_range(0, 1));
      nb  = 1'($urandom_range(0, 1));
      c   = $urandom_range(1, 3);
      pr  = (c & 1) != 0;
      pb  = (c & 2) != 0;
      clr = ($urandom_range(0, 7) == 0);
      off = $urandom_range(0, 6);
      trial(nr, nb, off, pr, pb, clr);
      settle();
    end

    #1 chk("delete_total", 32'(del_cnt), 32'(m_del));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
